lcd_cmd_arbiter: RTL and testbench
==================================

LCD_CMD_ARBITER -- requirements
Module: lcd_cmd_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning WAIT cycles before abort (used only with LCD_ARB_TIMEOUT_EN).
REQ-002 SHALL have port pclk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port init_finish  in  1  LCD init sequence complete.
REQ-005 SHALL have port req_i  in  3  request per requester; 0=init, 1=cpu draw, 2=id/readback.
REQ-006 SHALL have port cmd0_i  in  20  requester 0 command {read_color, id_fm, wr, rs, data[15:0]}.
REQ-007 SHALL have port cmd1_i  in  20  requester 1 command, same packing.
REQ-008 SHALL have port cmd2_i  in  20  requester 2 command, same packing.
REQ-009 SHALL have port ack_o  out  3  one-hot completion pulse per requester.
REQ-010 SHALL have port rdata_o  out  16  read data, valid while ack_o!=0.
REQ-011 SHALL have port timeout_o  out  1  pulse marking an aborted transaction.
REQ-012 SHALL have port lcd_we_o  out  1  one-cycle issue strobe to LCD interface.
REQ-013 SHALL have port lcd_cmd_o  out  20  latched command to LCD interface.
REQ-014 SHALL have port lcd_busy_i  in  1  interface cannot accept a command.
REQ-015 SHALL have port lcd_done_i  in  1  interface finished current command.
REQ-016 SHALL have port lcd_rdata_i  in  16  interface read data, valid with lcd_done_i.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, ACK.
REQ-018 Eligibility SHALL be: requester 0 only while init_finish=0; requesters 1,2 only while init_finish=1; ineligible requests are held pending, never acked.
REQ-019 IDLE SHALL go to ISSUE when an eligible request exists and lcd_busy_i=0; otherwise IDLE holds.
REQ-020 Between 1 and 2 SHALL use round-robin: pointer holds last granted, reset value 2, so 1 wins the first tie; the pointer updates on entry to ISSUE.
REQ-021 On IDLE->ISSUE SHALL latch the granted index and command; lcd_cmd_o SHALL hold the latched value until the next grant.
REQ-022 ISSUE SHALL last exactly one cycle with lcd_we_o=1, then go to WAIT; lcd_we_o SHALL be 0 in every other state.
REQ-023 WAIT SHALL sample lcd_done_i only in WAIT (done during ISSUE ignored); on done, capture lcd_rdata_i and go to ACK.
REQ-024 ACK SHALL last one cycle with ack_o bit of the granted index =1 and rdata_o = captured data, then go to IDLE.
REQ-025 Latency: request at idle cycle N with busy=0 -> lcd_we_o at N+1; ack at one cycle after the done-sampling cycle.
REQ-026 Requester SHALL hold req and cmd until ack, then deassert req the next cycle; a req dropped before ack SHALL NOT cancel an in-flight transaction (ack still pulses).
REQ-027 init_finish changing mid-transaction SHALL NOT abort it; it completes and acks the original requester, and the new eligibility applies from the next IDLE.
REQ-028 rdata_o SHALL be 0 outside ACK; for write commands it SHALL carry whatever lcd_rdata_i held at done.

Reset
REQ-029 On rst SHALL be: state IDLE, pointer 2, lcd_we_o=0, lcd_cmd_o=0, ack_o=0, rdata_o=0, timeout_o=0, watchdog=0; reset mid-transaction drops it without ack.

Configuration
REQ-030 With LCD_ARB_TIMEOUT_EN defined, a WAIT counter cleared on entry SHALL, on reaching TIMEOUT_CYCLES without done, force ACK with rdata_o=16'hFFFF and timeout_o=1 for that cycle.
REQ-031 Without LCD_ARB_TIMEOUT_EN, timeout_o SHALL be tied 0, no counter SHALL exist, and WAIT SHALL wait indefinitely.

Verification
REQ-032 init_finish=0, req_i=3'b111, cmd0=0x1_2A00 -> lcd_we_o 1 cycle later with lcd_cmd_o=0x1_2A00; only ack_o=001 after done.
REQ-033 init_finish=1, req 1 and 2 held continuously, each acking -> grants alternate 1,2,1,2, first grant to 1.
REQ-034 lcd_busy_i=1 for 5 cycles with req_i=010 -> no lcd_we_o until the cycle after busy falls.
REQ-035 Read on requester 2, lcd_rdata_i=0xBEEF with done -> ack_o=100 and rdata_o=0xBEEF in the same cycle.
REQ-036 LCD_ARB_TIMEOUT_EN set, done never asserted -> after 1023 WAIT cycles ack pulses with timeout_o=1 and rdata_o=0xFFFF; not set -> stays in WAIT.
REQ-037 rst asserted during WAIT -> next cycle all outputs 0 and a new request is granted normally.

Source files
------------

// File: rtl/lcd_cmd_arbiter.sv
// Arbitrates init/cpu/readback command requesters onto a single LCD interface.
// Optional WAIT watchdog enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_cmd_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        init_finish,
    input  logic [2:0]  req_i,
    input  logic [19:0] cmd0_i,
    input  logic [19:0] cmd1_i,
    input  logic [19:0] cmd2_i,
    output logic [2:0]  ack_o,
    output logic [15:0] rdata_o,
    output logic        timeout_o,
    output logic        lcd_we_o,
    output logic [19:0] lcd_cmd_o,
    input  logic        lcd_busy_i,
    input  logic        lcd_done_i,
    input  logic [15:0] lcd_rdata_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]  state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [19:0] cmd_q, cmd_d;
    logic [15:0] rdata_q, rdata_d;
    logic        to_q, to_d;

    logic        sel_vld;
    logic [1:0]  sel_idx;
    logic [19:0] sel_cmd;

    // Requester 0 owns the bus before init completes; 1 and 2 share it afterwards.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = 2'd0;
        if (!init_finish) begin
            sel_vld = req_i[0];
            sel_idx = 2'd0;
        end else if (req_i[1] && req_i[2]) begin
            sel_vld = 1'b1;
            sel_idx = (ptr_q == 2'd1) ? 2'd2 : 2'd1;
        end else if (req_i[1]) begin
            sel_vld = 1'b1;
            sel_idx = 2'd1;
        end else if (req_i[2]) begin
            sel_vld = 1'b1;
            sel_idx = 2'd2;
        end
    end

    always_comb begin
        case (sel_idx)
            2'd1:    sel_cmd = cmd1_i;
            2'd2:    sel_cmd = cmd2_i;
            default: sel_cmd = cmd0_i;
        endcase
    end

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q;
    logic            wd_expired;

    // Counts WAIT cycles; zero whenever the FSM is outside WAIT.
    always_ff @(posedge pclk) begin
        if (rst || state_q != WAIT) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end

    assign wd_expired = (wd_q == WD_LAST);
`else
    logic wd_expired;
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cmd_d   = cmd_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (sel_vld && !lcd_busy_i) begin
                    state_d = ISSUE;
                    gnt_d   = sel_idx;
                    cmd_d   = sel_cmd;
                    if (sel_idx != 2'd0) begin
                        ptr_d = sel_idx;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                to_d    = 1'b0;
            end
            WAIT: begin
                if (lcd_done_i) begin
                    state_d = ACK;
                    rdata_d = lcd_rdata_i;
                    to_d    = 1'b0;
                end else if (wd_expired) begin
                    state_d = ACK;
                    rdata_d = 16'hFFFF;
                    to_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd2;
            gnt_q   <= 2'd0;
            cmd_q   <= '0;
            rdata_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cmd_q   <= cmd_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
        end
    end

    assign lcd_we_o  = (state_q == ISSUE);
    assign lcd_cmd_o = cmd_q;
    assign ack_o     = (state_q == ACK) ? (3'b001 << gnt_q) : 3'b000;
    assign rdata_o   = (state_q == ACK) ? rdata_q : 16'h0000;
`ifdef LCD_ARB_TIMEOUT_EN
    assign timeout_o = (state_q == ACK) && to_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed bench for lcd_cmd_arbiter; covers the default and LCD_ARB_TIMEOUT_EN builds.
module tb_lcd_cmd_arbiter;

    logic        pclk;
    logic        rst;
    logic        init_finish;
    logic [2:0]  req_i;
    logic [19:0] cmd0_i, cmd1_i, cmd2_i;
    logic [2:0]  ack_o;
    logic [15:0] rdata_o;
    logic        timeout_o;
    logic        lcd_we_o;
    logic [19:0] lcd_cmd_o;
    logic        lcd_busy_i;
    logic        lcd_done_i;
    logic [15:0] lcd_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [19:0] C0 = 20'h1_2A00;
    localparam logic [19:0] C1 = 20'h0_AAAA;
    localparam logic [19:0] C2 = 20'hC_BBBB;

    lcd_cmd_arbiter #(.TIMEOUT_CYCLES(1023)) dut (
        .pclk        (pclk),
        .rst         (rst),
        .init_finish (init_finish),
        .req_i       (req_i),
        .cmd0_i      (cmd0_i),
        .cmd1_i      (cmd1_i),
        .cmd2_i      (cmd2_i),
        .ack_o       (ack_o),
        .rdata_o     (rdata_o),
        .timeout_o   (timeout_o),
        .lcd_we_o    (lcd_we_o),
        .lcd_cmd_o   (lcd_cmd_o),
        .lcd_busy_i  (lcd_busy_i),
        .lcd_done_i  (lcd_done_i),
        .lcd_rdata_i (lcd_rdata_i)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts in IDLE with the request already driven; runs issue, wait, done and ack.
    task automatic do_txn(input string tag, input logic [2:0] exp_ack,
                          input logic [19:0] exp_cmd, input logic [15:0] rd);
        tick();
        chk({tag, "_we"}, 32'(lcd_we_o), 32'd1);
        chk({tag, "_cmd"}, 32'(lcd_cmd_o), 32'(exp_cmd));
        tick();
        chk({tag, "_we_wait"}, 32'(lcd_we_o), 32'd0);
        lcd_done_i  = 1'b1;
        lcd_rdata_i = rd;
        tick();
        lcd_done_i  = 1'b0;
        chk({tag, "_ack"}, 32'(ack_o), 32'(exp_ack));
        chk({tag, "_rdata"}, 32'(rdata_o), 32'(rd));
        tick();
        chk({tag, "_ack_clr"}, 32'(ack_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1; init_finish = 1'b0; req_i = 3'b000;
        cmd0_i = C0; cmd1_i = C1; cmd2_i = C2;
        lcd_busy_i = 1'b0; lcd_done_i = 1'b0; lcd_rdata_i = 16'h0000;
        tick();
        tick();
        chk("rst_we", 32'(lcd_we_o), 32'd0);
        chk("rst_cmd", 32'(lcd_cmd_o), 32'd0);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_rdata", 32'(rdata_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);

        // Before init only requester 0 is eligible.
        rst = 1'b0;
        req_i = 3'b111;
        tick();
        chk("init_we", 32'(lcd_we_o), 32'd1);
        chk("init_cmd", 32'(lcd_cmd_o), 32'(C0));
        tick();
        chk("init_we_wait", 32'(lcd_we_o), 32'd0);
        lcd_done_i = 1'b1; lcd_rdata_i = 16'h1234;
        tick();
        lcd_done_i = 1'b0;
        req_i = 3'b000;
        chk("init_ack", 32'(ack_o), 32'b001);
        chk("init_wr_rdata", 32'(rdata_o), 32'h1234);
        tick();
        chk("init_ack_clr", 32'(ack_o), 32'd0);
        chk("init_rdata_clr", 32'(rdata_o), 32'd0);
        chk("init_cmd_hold", 32'(lcd_cmd_o), 32'(C0));

        // Round-robin between 1 and 2 with both held; 1 wins the first tie.
        init_finish = 1'b1;
        req_i = 3'b110;
        do_txn("rr0", 3'b010, C1, 16'h0001);
        do_txn("rr1", 3'b100, C2, 16'h0002);
        do_txn("rr2", 3'b010, C1, 16'h0003);
        do_txn("rr3", 3'b100, C2, 16'h0004);

        // Busy holds the grant off until it falls.
        req_i = 3'b010;
        lcd_busy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_no_we", 32'(lcd_we_o), 32'd0);
        end
        lcd_busy_i = 1'b0;
        do_txn("busy_rel", 3'b010, C1, 16'h5A5A);

        // Read on requester 2; a done pulse during ISSUE must be ignored.
        req_i = 3'b100;
        tick();
        chk("rd_we", 32'(lcd_we_o), 32'd1);
        chk("rd_cmd", 32'(lcd_cmd_o), 32'(C2));
        lcd_done_i = 1'b1; lcd_rdata_i = 16'hDEAD;
        tick();
        lcd_done_i = 1'b0;
        chk("rd_issue_done_ignored", 32'(ack_o), 32'd0);
        tick();
        chk("rd_still_wait", 32'(ack_o), 32'd0);
        lcd_done_i = 1'b1; lcd_rdata_i = 16'hBEEF;
        tick();
        lcd_done_i = 1'b0;
        req_i = 3'b000;
        chk("rd_ack", 32'(ack_o), 32'b100);
        chk("rd_rdata", 32'(rdata_o), 32'hBEEF);
        tick();
        chk("rd_ack_clr", 32'(ack_o), 32'd0);

        // init_finish flip and req drop mid-transaction still complete requester 0.
        init_finish = 1'b0;
        req_i = 3'b001;
        tick();
        chk("flip_we", 32'(lcd_we_o), 32'd1);
        chk("flip_cmd", 32'(lcd_cmd_o), 32'(C0));
        init_finish = 1'b1;
        req_i = 3'b000;
        tick();
        lcd_done_i = 1'b1; lcd_rdata_i = 16'h0F0F;
        tick();
        lcd_done_i = 1'b0;
        chk("flip_ack", 32'(ack_o), 32'b001);
        chk("flip_rdata", 32'(rdata_o), 32'h0F0F);
        tick();
        chk("flip_idle", 32'(lcd_we_o), 32'd0);

        // Done never arrives.
        req_i = 3'b010;
        tick();
        chk("to_we", 32'(lcd_we_o), 32'd1);
        req_i = 3'b000;
        tick();
`ifdef LCD_ARB_TIMEOUT_EN
        begin
            int early = 0;
            for (int i = 0; i < 1022; i++) begin
                tick();
                if (ack_o != 3'b000 || timeout_o != 1'b0) early++;
            end
            chk("to_no_early_ack", 32'(early), 32'd0);
        end
        tick();
        chk("to_ack", 32'(ack_o), 32'b010);
        chk("to_flag", 32'(timeout_o), 32'd1);
        chk("to_rdata", 32'(rdata_o), 32'hFFFF);
        tick();
        chk("to_flag_clr", 32'(timeout_o), 32'd0);
        req_i = 3'b010;
        tick();
        req_i = 3'b000;
        tick();
`else
        begin
            int spurious = 0;
            for (int i = 0; i < 1100; i++) begin
                tick();
                if (ack_o != 3'b000 || timeout_o != 1'b0 || lcd_we_o != 1'b0) spurious++;
            end
            chk("to_stays_wait", 32'(spurious), 32'd0);
        end
`endif

        // Reset while in WAIT drops the transaction; the pointer returns to 2.
        rst = 1'b1;
        tick();
        chk("wrst_we", 32'(lcd_we_o), 32'd0);
        chk("wrst_cmd", 32'(lcd_cmd_o), 32'd0);
        chk("wrst_ack", 32'(ack_o), 32'd0);
        chk("wrst_rdata", 32'(rdata_o), 32'd0);
        chk("wrst_timeout", 32'(timeout_o), 32'd0);
        rst = 1'b0;
        req_i = 3'b110;
        do_txn("post_rst", 3'b010, C1, 16'hA55A);
        req_i = 3'b000;
        tick();
        chk("post_rst_idle", 32'(lcd_we_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
